audio_tick_sched: RTL and testbench
===================================

AUDIO_TICK_SCHED -- requirements
Module: audio_tick_sched

Interface
REQ-001 SHALL have parameter CTRL_RUN, default 16'h0007, the control word written to start the timer (ITO=1, CONT=1, START=1).
REQ-002 SHALL have parameter CTRL_STOP, default 16'h0008, the control word written to stop the timer.
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port enable  in  1  level request to run the sample timer.
REQ-006 SHALL have port tick_valid  out  1  a sample-tick is pending for the consumer.
REQ-007 SHALL have port tick_ready  in  1  the consumer accepts the tick when tick_valid=1.
REQ-008 SHALL have port tick_count  out  16  count of timer timeouts since reset, wrapping.
REQ-009 SHALL have port overrun  out  1  sticky flag: a timeout arrived while a tick was still pending.
REQ-010 SHALL have port overrun_clr  in  1  synchronous clear of overrun.
REQ-011 SHALL have ports host_req in 1, host_addr in 3, host_wr in 1, host_wdata in 16: a single-cycle host access request, held until granted.
REQ-012 SHALL have ports host_gnt out 1, host_rvalid out 1, host_rdata out 16, host_err out 1: grant, read-data valid, read data, and protected-write drop.
REQ-013 SHALL have ports tmr_address out 3, tmr_chipselect out 1, tmr_write_n out 1, tmr_writedata out 16, tmr_readdata in 16, tmr_irq in 1: the timer slave port, with 1-cycle registered read latency.

Function
REQ-014 SHALL implement the FSM states IDLE, CFG, RUN, ACK, STOP, each lasting one cycle except IDLE and RUN.
REQ-015 IDLE SHALL go to CFG when enable=1.
REQ-016 CFG SHALL drive tmr_chipselect=1, tmr_write_n=0, tmr_address=1, tmr_writedata=CTRL_RUN, then go to RUN.
REQ-017 RUN SHALL go to ACK when tmr_irq=1, giving tmr_irq priority over enable=0 in the same cycle, and SHALL otherwise go to STOP when enable=0.
REQ-018 ACK SHALL write 16'h0000 to address 0 to clear the timer timeout status, then go to STOP if enable=0, else go to RUN.
REQ-019 STOP SHALL write CTRL_STOP to address 1, then go to IDLE.
REQ-020 In the ACK cycle, tick_count SHALL increment modulo 2^16; tick_valid SHALL set on the following edge.
REQ-021 In the ACK cycle, if tick_valid=1 and tick_ready=0, overrun SHALL set and tick_valid SHALL stay 1, so that only one tick is pending at any time.
REQ-022 tick_valid SHALL clear on the edge where tick_valid=1 and tick_ready=1, unless a new ACK occurs in the same cycle, in which case it SHALL stay 1 and overrun SHALL NOT set.
REQ-023 overrun_clr SHALL clear overrun; if a set condition occurs in the same cycle, the set SHALL win.
REQ-024 Arbitration: sequencer accesses in CFG, ACK and STOP SHALL own the timer port; host_gnt SHALL be asserted for one cycle only in IDLE or RUN, only with host_req=1, and only when the same cycle does not transition into CFG, ACK or STOP.
REQ-025 In a grant cycle, the host fields SHALL drive the timer port combinationally (tmr_chipselect=1, tmr_write_n=~host_wr).
REQ-026 A granted host read SHALL produce host_rvalid=1 for one cycle on the next cycle, with host_rdata=tmr_readdata.
REQ-027 With enable=1 or FSM≠IDLE, a granted host write to address 0 or 1 SHALL be dropped: tmr_chipselect=0 and host_err=1 for that cycle. Writes to addresses 2-5 SHALL pass through.
REQ-028 Outside sequencer or granted-host cycles, the timer port SHALL drive tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
REQ-029 The minimum timeout-to-ACK latency SHALL be 1 cycle after tmr_irq is sampled high; back-to-back grants SHALL NOT delay an ACK.

Reset
REQ-030 Asserting reset_n=0 SHALL force state IDLE, tick_valid=0, tick_count=0, overrun=0, host_gnt=0, host_rvalid=0, host_err=0, host_rdata=0, and the idle timer-port values, in every state.
REQ-031 A reset in RUN SHALL NOT issue a STOP write; the timer is reset by the same reset_n.

Verification
REQ-032 Reset, then enable=1 with timer period 0xC34F: CFG write of 0x0007 to address 1, then the first tick_valid about 50001 cycles later with tick_count=1.
REQ-033 Hold tick_ready=0 across two timeouts: overrun=1, a single tick_valid, tick_count=2; overrun_clr pulsed together with a third timeout leaves overrun=1.
REQ-034 Host read of address 0 during RUN: host_gnt for 1 cycle, host_rvalid on the next cycle with host_rdata=16'h0002 (counter running, no timeout).
REQ-035 host_req held high while tmr_irq rises: ACK write wins, host_gnt is delayed one cycle, and no cycle drives both accesses.
REQ-036 enable dropped in the same cycle as tmr_irq: sequence RUN→ACK→STOP→IDLE, with writes 0x0000@0 then 0x0008@1; a host write of 0x0004 to address 1 while enabled gives host_err=1 and tmr_chipselect=0.
REQ-037 reset_n pulsed low in ACK: all outputs return to their reset values immediately, and the next enable=1 repeats the CFG write.

Source files
------------

// File: rtl/audio_tick_sched.sv
// audio_tick_sched
//   Sequences a memory-mapped interval timer that produces the audio sample
//   tick, and shares the timer slave port with a host.
//   - A small FSM programs the timer (CFG), acknowledges each timeout (ACK)
//     and stops it again (STOP). It follows the level request 'enable'.
//   - Every acknowledged timeout raises a single pending tick towards a
//     consumer (tick_valid/tick_ready). A timeout that arrives while a tick
//     is still pending sets the sticky 'overrun' flag.
//   - The host may reach the timer only in IDLE or RUN cycles that do not
//     hand the port to the sequencer. While the timer is in use, host writes
//     to the status/control registers (addresses 0 and 1) are dropped.
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   enable                        level request to run the sample timer
//   tick_valid / tick_ready       pending sample tick and its acceptance
//   tick_count[15:0]              timeouts since reset, wrapping
//   overrun / overrun_clr         sticky overrun flag and its sync clear
//   host_req/addr/wr/wdata        host access request, held until granted
//   host_gnt/rvalid/rdata/err     grant, read return, dropped-write flag
//   tmr_*                         timer slave port (1-cycle read latency)
module audio_tick_sched #(
    parameter logic [15:0] CTRL_RUN  = 16'h0007,
    parameter logic [15:0] CTRL_STOP = 16'h0008
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic        tick_valid,
    input  logic        tick_ready,
    output logic [15:0] tick_count,
    output logic        overrun,
    input  logic        overrun_clr,
    input  logic        host_req,
    input  logic [2:0]  host_addr,
    input  logic        host_wr,
    input  logic [15:0] host_wdata,
    output logic        host_gnt,
    output logic        host_rvalid,
    output logic [15:0] host_rdata,
    output logic        host_err,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq
);

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        RUN,
        ACK,
        STOP
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        seq_access;
    logic [2:0]  seq_addr;
    logic [15:0] seq_data;

    logic        host_window;
    logic        host_grant_raw;
    logic        host_protected;
    logic        ack_now;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        seq_access = 1'b0;
        seq_addr   = '0;
        seq_data   = '0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = CFG;
                end
            end
            CFG: begin
                seq_access = 1'b1;
                seq_addr   = 3'd1;
                seq_data   = CTRL_RUN;
                state_next = RUN;
            end
            RUN: begin
                // A timeout is always acknowledged before honouring a stop.
                if (tmr_irq) begin
                    state_next = ACK;
                end else if (!enable) begin
                    state_next = STOP;
                end
            end
            ACK: begin
                seq_access = 1'b1;
                seq_addr   = 3'd0;
                seq_data   = 16'h0000;
                state_next = enable ? RUN : STOP;
            end
            STOP: begin
                seq_access = 1'b1;
                seq_addr   = 3'd1;
                seq_data   = CTRL_STOP;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Host arbitration
    // ------------------------------------------------------------------
    // The host owns the port only in IDLE/RUN cycles that stay put; a cycle
    // heading into CFG, ACK or STOP keeps the grant back so the sequencer
    // access in the following cycle is never delayed.
    assign host_window    = ((state == IDLE) || (state == RUN)) && (state_next == state);
    assign host_grant_raw = host_req && host_window;
    // Gated by reset_n so the grant is low throughout reset, not just after it.
    assign host_gnt       = host_grant_raw && reset_n;

    // Status/control belong to the sequencer while the timer is in use.
    assign host_protected = host_wr && (host_addr < 3'd2) && (enable || (state != IDLE));
    assign host_err       = host_gnt && host_protected;

    // ------------------------------------------------------------------
    // Timer port multiplexer
    // ------------------------------------------------------------------
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = '0;
        tmr_writedata  = '0;
        if (seq_access) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
            tmr_address    = seq_addr;
            tmr_writedata  = seq_data;
        end else if (host_gnt && !host_protected) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = ~host_wr;
            tmr_address    = host_addr;
            tmr_writedata  = host_wdata;
        end
    end

    // Timer read data arrives one cycle after the granted read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_rvalid <= 1'b0;
        end else begin
            host_rvalid <= host_grant_raw && !host_wr;
        end
    end

    assign host_rdata = host_rvalid ? tmr_readdata : '0;

    // ------------------------------------------------------------------
    // Sample tick, timeout counter and overrun
    // ------------------------------------------------------------------
    assign ack_now = (state == ACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_valid <= 1'b0;
            tick_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (ack_now) begin
                tick_count <= tick_count + 16'd1;
                tick_valid <= 1'b1;
            end else if (tick_valid && tick_ready) begin
                tick_valid <= 1'b0;
            end

            // A tick accepted in the ACK cycle makes room for the new one,
            // so only an unaccepted pending tick counts as an overrun.
            if (ack_now && tick_valid && !tick_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_tick_sched.sv
module tb_audio_tick_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        tick_valid;
    logic        tick_ready;
    logic [15:0] tick_count;
    logic        overrun;
    logic        overrun_clr;
    logic        host_req;
    logic [2:0]  host_addr;
    logic        host_wr;
    logic [15:0] host_wdata;
    logic        host_gnt;
    logic        host_rvalid;
    logic [15:0] host_rdata;
    logic        host_err;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    always #5 clk = ~clk;

    audio_tick_sched #(
        .CTRL_RUN (16'h0007),
        .CTRL_STOP(16'h0008)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .tick_valid    (tick_valid),
        .tick_ready    (tick_ready),
        .tick_count    (tick_count),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .host_req      (host_req),
        .host_addr     (host_addr),
        .host_wr       (host_wr),
        .host_wdata    (host_wdata),
        .host_gnt      (host_gnt),
        .host_rvalid   (host_rvalid),
        .host_rdata    (host_rdata),
        .host_err      (host_err),
        .tmr_address   (tmr_address),
        .tmr_chipselect(tmr_chipselect),
        .tmr_write_n   (tmr_write_n),
        .tmr_writedata (tmr_writedata),
        .tmr_readdata  (tmr_readdata),
        .tmr_irq       (tmr_irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: {valid, address, data} of expected timer writes, and
    // expected host read data.
    logic [19:0] seq_q[$];
    logic [19:0] host_q[$];
    logic [15:0] rd_q[$];

    // ------------------------------------------------------------------
    // Timer model: 0 status {run,to}, 1 control {stop,start,cont,ito},
    // 2 period (write reloads the counter). Timeout every period+1 cycles.
    // ------------------------------------------------------------------
    logic [15:0] m_period, m_cnt, m_ctrl, m_rdata;
    logic        m_run, m_to;
    int unsigned exp_count;

    assign tmr_irq      = m_to & m_ctrl[0];
    assign tmr_readdata = m_rdata;

    always @(posedge clk or negedge reset_n) begin : timer_model
        logic tmo;
        logic wr;
        if (!reset_n) begin
            m_period  <= 16'hC34F;
            m_cnt     <= 16'h0;
            m_ctrl    <= 16'h0;
            m_run     <= 1'b0;
            m_to      <= 1'b0;
            m_rdata   <= 16'h0;
            exp_count = 0;
            seq_q.delete();
        end else begin
            tmo = m_run && (m_cnt == 16'h0);
            wr  = tmr_chipselect && !tmr_write_n;
            if (tmr_chipselect && tmr_write_n) begin
                case (tmr_address)
                    3'd0:    m_rdata <= {14'h0, m_run, m_to};
                    3'd1:    m_rdata <= m_ctrl;
                    3'd2:    m_rdata <= m_period;
                    default: m_rdata <= 16'h0;
                endcase
            end
            if (m_run) m_cnt <= (m_cnt == 16'h0) ? m_period : m_cnt - 16'd1;
            if (tmo && !m_ctrl[1]) m_run <= 1'b0;
            if (wr) begin
                case (tmr_address)
                    3'd1: begin
                        m_ctrl <= tmr_writedata;
                        if (tmr_writedata[2]) begin
                            m_run <= 1'b1;
                            m_cnt <= m_period;
                        end else if (tmr_writedata[3]) begin
                            m_run <= 1'b0;
                        end
                    end
                    3'd2: begin
                        m_period <= tmr_writedata;
                        m_cnt    <= tmr_writedata;
                    end
                    default: ;
                endcase
            end
            if (tmo) begin
                m_to <= 1'b1;
                if (m_ctrl[0] && !m_to) begin
                    seq_q.push_back({1'b1, 3'd0, 16'h0000});
                    exp_count++;
                end
            end else if (wr && tmr_address == 3'd0) begin
                m_to <= 1'b0;
            end
        end
    end

    // Write monitor: every write on the timer port must match the head of
    // the scoreboard belonging to its owner.
    always @(negedge clk) begin : wr_monitor
        logic [19:0] obs;
        logic [19:0] exp;
        if (reset_n && tmr_chipselect && !tmr_write_n) begin
            obs = {1'b1, tmr_address, tmr_writedata};
            exp = 20'h0;
            if (host_gnt) begin
                if (host_q.size() > 0) exp = host_q.pop_front();
                check_val("host_wr", 32'(obs), 32'(exp));
            end else begin
                if (seq_q.size() > 0) exp = seq_q.pop_front();
                check_val("seq_wr", 32'(obs), 32'(exp));
            end
        end
    end

    always @(negedge clk) begin : rd_monitor
        logic [15:0] exp;
        if (host_rvalid) begin
            exp = 16'hDEAD;
            if (rd_q.size() > 0) exp = rd_q.pop_front();
            check_val("host_rdata", 32'(host_rdata), 32'(exp));
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tick_valid"}, 32'(tick_valid), 0);
        check_val({tag, "_tick_count"}, 32'(tick_count), 0);
        check_val({tag, "_overrun"}, 32'(overrun), 0);
        check_val({tag, "_host_gnt"}, 32'(host_gnt), 0);
        check_val({tag, "_host_rvalid"}, 32'(host_rvalid), 0);
        check_val({tag, "_host_err"}, 32'(host_err), 0);
        check_val({tag, "_host_rdata"}, 32'(host_rdata), 0);
        check_val({tag, "_tmr_port"},
                  32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
                  32'({1'b0, 1'b1, 3'd0, 16'h0}));
    endtask

    // Issue one host access and follow it to completion; ends #1 after an edge.
    task automatic host_access(input logic [2:0] addr, input logic wr, input logic [15:0] wdata,
                               input logic exp_err, input logic [15:0] rexp);
        bit got = 0;
        host_req   = 1'b1;
        host_addr  = addr;
        host_wr    = wr;
        host_wdata = wdata;
        if (!wr) rd_q.push_back(rexp);
        else if (!exp_err) host_q.push_back({1'b1, addr, wdata});
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (host_gnt) got = 1;
            else next_cycle();
        end
        check_val("host_gnt_seen", 32'(got), 1);
        check_val("host_err", 32'(host_err), 32'(exp_err));
        if (exp_err) check_val("dropped_cs", 32'(tmr_chipselect), 0);
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        check_val("host_gnt_one_cycle", 32'(host_gnt), 0);
        check_val("host_rvalid", 32'(host_rvalid), 32'(!wr));
        next_cycle();
    endtask

    // Ends #1 after the edge on which the model raises its timeout.
    task automatic to_irq_cycle(input int bound);
        bit got = 0;
        for (int i = 0; i < bound && !got; i++) begin
            @(negedge clk);
            if (m_run && m_cnt == 16'h0 && m_ctrl[0] && !m_to) got = 1;
            next_cycle();
        end
        check_val("timeout_reached", 32'(got), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        reset_n     = 1'b0;
        enable      = 1'b0;
        tick_ready  = 1'b0;
        overrun_clr = 1'b0;
        host_req    = 1'b1;
        host_addr   = 3'd0;
        host_wr     = 1'b0;
        host_wdata  = 16'h0;

        // Reset: host request outstanding in IDLE must not be granted.
        repeat (3) next_cycle();
        @(negedge clk);
        check_reset_outputs("reset");

        // Start: CFG write, then the first tick about 50000 cycles later.
        next_cycle();
        host_req = 1'b0;
        reset_n  = 1'b1;
        enable   = 1'b1;
        seq_q.push_back({1'b1, 3'd1, 16'h0007});
        @(negedge clk);
        check_val("idle_port", 32'(tmr_chipselect), 0);
        next_cycle();
        @(negedge clk);
        check_val("cfg_cycle",
                  32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
                  32'({1'b1, 1'b0, 3'd1, 16'h0007}));
        lat  = 1;
        seen = 0;
        while (lat < 50100 && !seen) begin
            next_cycle();
            lat++;
            @(negedge clk);
            if (tick_valid) seen = 1;
        end
        check_val("first_tick_seen", 32'(seen), 1);
        check_val("first_tick_latency", 32'(lat >= 49995 && lat <= 50010), 1);
        check_val("first_tick_count", 32'(tick_count), 1);

        next_cycle();
        tick_ready = 1'b1;
        next_cycle();
        tick_ready = 1'b0;
        @(negedge clk);
        check_val("tick_consumed", 32'(tick_valid), 0);
        next_cycle();

        // Period registers are open to the host while running.
        host_access(3'd2, 1'b1, 16'd19, 1'b0, 16'h0);
        host_access(3'd3, 1'b1, 16'd0, 1'b0, 16'h0);
        host_access(3'd0, 1'b0, 16'h0, 1'b0, 16'h0002);
        host_access(3'd2, 1'b0, 16'h0, 1'b0, 16'd19);

        // Two timeouts without acceptance: one pending tick, overrun set.
        to_irq_cycle(100);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("second_tick_valid", 32'(tick_valid), 1);
        check_val("no_overrun_yet", 32'(overrun), 0);
        to_irq_cycle(100);
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("overrun_set", 32'(overrun), 1);
        check_val("single_tick_pending", 32'(tick_valid), 1);
        check_val("count_after_overrun", 32'(tick_count), exp_count);

        // Clear in the same cycle as a new set: set wins.
        to_irq_cycle(100);
        next_cycle();
        overrun_clr = 1'b1;
        next_cycle();
        overrun_clr = 1'b0;
        @(negedge clk);
        check_val("clr_vs_set", 32'(overrun), 1);
        next_cycle();
        overrun_clr = 1'b1;
        next_cycle();
        overrun_clr = 1'b0;
        @(negedge clk);
        check_val("overrun_cleared", 32'(overrun), 0);

        // Acceptance in the ACK cycle: tick stays pending, no overrun.
        to_irq_cycle(100);
        next_cycle();
        tick_ready = 1'b1;
        next_cycle();
        tick_ready = 1'b0;
        @(negedge clk);
        check_val("ack_accept_valid", 32'(tick_valid), 1);
        check_val("ack_accept_no_overrun", 32'(overrun), 0);
        check_val("ack_accept_count", 32'(tick_count), exp_count);
        next_cycle();
        tick_ready = 1'b1;
        next_cycle();
        tick_ready = 1'b0;
        @(negedge clk);
        check_val("tick_cleared", 32'(tick_valid), 0);
        next_cycle();

        // Host request present as the timeout arrives: ACK goes first.
        to_irq_cycle(100);
        host_req  = 1'b1;
        host_addr = 3'd2;
        host_wr   = 1'b0;
        rd_q.push_back(16'd19);
        @(negedge clk);
        check_val("gnt_in_irq_cycle", 32'(host_gnt), 0);
        next_cycle();
        @(negedge clk);
        check_val("gnt_in_ack", 32'(host_gnt), 0);
        check_val("ack_owns_port", 32'({tmr_chipselect, tmr_write_n, tmr_address}),
                  32'({1'b1, 1'b0, 3'd0}));
        next_cycle();
        @(negedge clk);
        check_val("gnt_after_ack", 32'(host_gnt), 1);
        next_cycle();
        host_req = 1'b0;
        @(negedge clk);
        check_val("rvalid_after_ack", 32'(host_rvalid), 1);
        next_cycle();

        // Protected writes while enabled are dropped.
        host_access(3'd1, 1'b1, 16'h0004, 1'b1, 16'h0);
        host_access(3'd0, 1'b1, 16'h0000, 1'b1, 16'h0);

        // enable drops with the timeout: ACK, STOP, IDLE.
        to_irq_cycle(100);
        enable = 1'b0;
        seq_q.push_back({1'b1, 3'd1, 16'h0008});
        next_cycle();
        @(negedge clk);
        check_val("ack_write", 32'({tmr_chipselect, tmr_address, tmr_writedata}),
                  32'({1'b1, 3'd0, 16'h0000}));
        next_cycle();
        @(negedge clk);
        check_val("stop_write", 32'({tmr_chipselect, tmr_address, tmr_writedata}),
                  32'({1'b1, 3'd1, 16'h0008}));
        next_cycle();
        @(negedge clk);
        check_val("idle_after_stop", 32'(tmr_chipselect), 0);
        next_cycle();

        // Idle and disabled: control register is writable by the host.
        host_access(3'd1, 1'b1, 16'h0008, 1'b0, 16'h0);

        // Reset in the ACK cycle.
        enable = 1'b1;
        seq_q.push_back({1'b1, 3'd1, 16'h0007});
        to_irq_cycle(100);
        next_cycle();
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("ack_reset");
        next_cycle();
        reset_n = 1'b1;
        seq_q.push_back({1'b1, 3'd1, 16'h0007});
        next_cycle();
        @(negedge clk);
        check_val("cfg_after_reset",
                  32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}),
                  32'({1'b1, 1'b0, 3'd1, 16'h0007}));
        next_cycle();
        enable = 1'b0;
        seq_q.push_back({1'b1, 3'd1, 16'h0008});
        repeat (4) next_cycle();

        check_val("seq_q_drained", seq_q.size(), 0);
        check_val("host_q_drained", host_q.size(), 0);
        check_val("rd_q_drained", rd_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
